// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback bus bundle for pipeline, long-latency unit
// and register-file write port; slave = arbiter, master = surroundings.
interface wb_arbiter_if;
  logic        pipe_regwrite;
  logic [4:0]  pipe_wsel;
  logic [31:0] pipe_wdat;
  logic        lu_issue;
  logic [4:0]  lu_issue_wsel;
  logic        lu_valid;
  logic [4:0]  lu_wsel;
  logic [31:0] lu_wdat;
  logic        lu_ready;
  logic        wb_stall;
  logic [31:0] busy;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;

  modport slave (
    input  pipe_regwrite, pipe_wsel, pipe_wdat,
    input  lu_issue, lu_issue_wsel,
    input  lu_valid, lu_wsel, lu_wdat,
    output lu_ready, wb_stall, busy,
    output WEN, wsel, wdat
  );

  modport master (
    output pipe_regwrite, pipe_wsel, pipe_wdat,
    output lu_issue, lu_issue_wsel,
    output lu_valid, lu_wsel, lu_wdat,
    input  lu_ready, wb_stall, busy,
    input  WEN, wsel, wdat
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter, pipeline vs long-latency skid FIFO.
// Define WB_STARVE_EN to enable the starvation guard (wb_stall).
module wb_arbiter #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         CLK,
  input logic         nRST,
  wb_arbiter_if.slave bus
);
  localparam int AW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    fifo_wsel [LU_DEPTH];
  logic [31:0]   fifo_wdat [LU_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          push, pop, sel_pipe, stall;
  logic [4:0]    head_wsel;
  logic [31:0]   head_wdat;
  logic [31:0]   busy_q, busy_d;
  logic          wen_q;
  logic [4:0]    wsel_q;
  logic [31:0]   wdat_q;

  assign empty     = count == '0;
  assign full      = count == CW'(LU_DEPTH);
  assign push      = bus.lu_valid && !full;
  assign sel_pipe  = !stall && bus.pipe_regwrite;
  assign pop       = !sel_pipe && !empty;
  assign head_wsel = fifo_wsel[rd_ptr];
  assign head_wdat = fifo_wdat[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_wsel[wr_ptr] <= bus.lu_wsel;
      fifo_wdat[wr_ptr] <= bus.lu_wdat;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set after clear so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_wsel] = 1'b0;
    if (bus.lu_issue) busy_d[bus.lu_issue_wsel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else begin
      busy_q <= busy_d;
      unique case (1'b1)
        sel_pipe: begin
          wen_q  <= bus.pipe_wsel != '0;
          wsel_q <= bus.pipe_wsel;
          wdat_q <= bus.pipe_wdat;
        end
        pop: begin
          wen_q  <= head_wsel != '0;
          wsel_q <= head_wsel;
          wdat_q <= head_wdat;
        end
        default: wen_q <= 1'b0;
      endcase
    end
  end

`ifdef WB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign stall = starve_q == SW'(STARVE_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)             starve_q <= '0;
    else if (empty || pop) starve_q <= '0;
    else if (sel_pipe)     starve_q <= starve_q + SW'(1);
  end
`else
  // Guard absent: FIFO drains only when the pipeline is idle.
  assign stall = 1'b0 && (STARVE_LIMIT > 0);
`endif

  assign bus.lu_ready = !full;
  assign bus.wb_stall = stall;
  assign bus.busy     = busy_q;
  assign bus.WEN      = wen_q;
  assign bus.wsel     = wsel_q;
  assign bus.wdat     = wdat_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors for wb_arbiter.
// Expected values are hand-computed; WB_STARVE_EN selects guard checks.
module tb_wb_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_arbiter_if bus();

  wb_arbiter #(
    .LU_DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] s,
                      input logic [31:0] d);
    bus.pipe_regwrite = v;
    bus.pipe_wsel     = s;
    bus.pipe_wdat     = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] s,
                    input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_wsel  = s;
    bus.lu_wdat  = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] s);
    bus.lu_issue      = v;
    bus.lu_issue_wsel = s;
  endtask

  initial begin
    logic st;
    logic [31:0] ew;
    nRST = 1'b0;
    pipe(0, 0, 0);
    lu(0, 0, 0);
    issue(0, 0);
    #2;
    check("rst_wen", 32'(bus.WEN), 0);
    check("rst_wsel", 32'(bus.wsel), 0);
    check("rst_wdat", bus.wdat, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", 32'(bus.lu_ready), 1);
    check("rst_stall", 32'(bus.wb_stall), 0);
    @(posedge CLK);
    #3 nRST = 1'b1;
    tick();

    // pipeline write, one-cycle WEN
    pipe(1, 5, 32'hDEADBEEF);
    tick();
    check("p_wen", 32'(bus.WEN), 1);
    check("p_wsel", 32'(bus.wsel), 5);
    check("p_wdat", bus.wdat, 32'hDEADBEEF);
    pipe(0, 0, 0);
    tick();
    check("p_wen_off", 32'(bus.WEN), 0);
    check("p_wsel_hold", 32'(bus.wsel), 5);

    // scoreboard set, FIFO write, clear on pop
    issue(1, 9);
    tick();
    check("busy9_set", bus.busy, 32'h200);
    issue(0, 0);
    lu(1, 9, 32'h12);
    tick();
    check("nobypass", 32'(bus.WEN), 0);
    lu(0, 0, 0);
    tick();
    check("lu_wen", 32'(bus.WEN), 1);
    check("lu_wsel", 32'(bus.wsel), 9);
    check("lu_wdat", bus.wdat, 32'h12);
    check("busy9_clr", bus.busy, 0);

    // pipeline priority over FIFO
    pipe(1, 3, 32'h33);
    lu(1, 4, 32'h44);
    tick();
    check("prio_wsel3", 32'(bus.wsel), 3);
    check("prio_wen3", 32'(bus.WEN), 1);
    pipe(0, 0, 0);
    lu(0, 0, 0);
    tick();
    check("prio_wsel4", 32'(bus.wsel), 4);
    check("prio_wdat4", bus.wdat, 32'h44);
    tick();
    check("prio_idle", 32'(bus.WEN), 0);

    // fill, full, push+pop, wrap
    check("ready_empty", 32'(bus.lu_ready), 1);
    pipe(1, 10, 32'hA0);
    lu(1, 11, 32'hB1);
    tick();
    check("ready_1", 32'(bus.lu_ready), 1);
    lu(1, 12, 32'hB2);
    tick();
    check("ready_2", 32'(bus.lu_ready), 0);
    lu(1, 13, 32'hB3);
    tick();
    check("ready_held", 32'(bus.lu_ready), 0);
    check("full_pipe", 32'(bus.wsel), 10);
    pipe(0, 0, 0);
    tick();
    check("drain_11", 32'(bus.wsel), 11);
    check("drain_b1", bus.wdat, 32'hB1);
    check("ready_back", 32'(bus.lu_ready), 1);
    tick();
    check("drain_12", 32'(bus.wsel), 12);
    lu(0, 0, 0);
    tick();
    check("drain_13", 32'(bus.wsel), 13);
    check("drain_b3", bus.wdat, 32'hB3);
    tick();
    check("drain_idle", 32'(bus.WEN), 0);
    check("drain_hold", 32'(bus.wsel), 13);

    // register 0
    pipe(1, 0, 32'h1);
    tick();
    check("r0_pipe", 32'(bus.WEN), 0);
    pipe(0, 0, 0);
    issue(1, 0);
    lu(1, 0, 32'h5);
    tick();
    check("r0_busy", bus.busy, 0);
    issue(0, 0);
    lu(1, 6, 32'h66);
    tick();
    check("r0_fifo", 32'(bus.WEN), 0);
    lu(0, 0, 0);
    tick();
    check("r0_next_wen", 32'(bus.WEN), 1);
    check("r0_next_wsel", 32'(bus.wsel), 6);
    check("r0_next_wdat", bus.wdat, 32'h66);

    // starvation guard
    pipe(1, 21, 32'h2121);
    lu(1, 20, 32'h2020);
    tick();
    check("sv_first", 32'(bus.wsel), 21);
    lu(0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
`ifdef WB_STARVE_EN
      st = (k == 4);
      ew = (k == 5) ? 32'd20 : 32'd21;
`else
      st = 1'b0;
      ew = 32'd21;
`endif
      check($sformatf("sv_stall_%0d", k), 32'(bus.wb_stall), 32'(st));
      check($sformatf("sv_wsel_%0d", k), 32'(bus.wsel), ew);
    end
    pipe(0, 0, 0);
    tick();
`ifdef WB_STARVE_EN
    check("sv_after", 32'(bus.WEN), 0);
`else
    check("sv_after", 32'(bus.wsel), 20);
    check("sv_after_wen", 32'(bus.WEN), 1);
`endif
    tick();
    check("sv_idle", 32'(bus.WEN), 0);

    // set wins over same-cycle clear
    issue(1, 7);
    tick();
    check("b7_set", bus.busy, 32'h80);
    issue(0, 0);
    pipe(1, 1, 32'h1);
    lu(1, 7, 32'h77);
    tick();
    pipe(0, 0, 0);
    lu(0, 0, 0);
    issue(1, 7);
    tick();
    issue(0, 0);
    check("b7_pop", 32'(bus.wsel), 7);
    check("b7_keep", bus.busy, 32'h80);

    // reset mid-stream
    pipe(1, 2, 32'h22);
    lu(1, 8, 32'h88);
    issue(1, 15);
    tick();
    check("pre_rst_busy", bus.busy, 32'h8080);
    pipe(0, 0, 0);
    lu(0, 0, 0);
    issue(0, 0);
    #2 nRST = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_ready", 32'(bus.lu_ready), 1);
    check("mrst_wen", 32'(bus.WEN), 0);
    check("mrst_wsel", 32'(bus.wsel), 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check("post_rst_wen", 32'(bus.WEN), 0);
    tick();
    check("post_rst_wen2", 32'(bus.WEN), 0);
    check("post_rst_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
